bfn_pred_queue: RTL and testbench
=================================

BFN_PRED_QUEUE -- requirements
Module: bfn_pred_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of in-flight prediction entries; legal values are powers of two, 2 to 16.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and is the reset: synchronous, active-high.
REQ-004 The port push_valid SHALL be an input, 1 bit wide, asserted by fetch when a predicted control-flow instruction is issued.
REQ-005 The port push_ready SHALL be an output, 1 bit wide, and is high when the queue can accept a push.
REQ-006 The push payload SHALL be inputs push_pc (32 bits), push_pc_predict (32 bits), push_prediction (1 bit), push_status (2 bits), push_bias (2 bits) and push_total_weights (9 bits).
REQ-007 The port resolve_valid SHALL be an input, 1 bit wide, asserted by EX when the oldest branch resolves.
REQ-008 The port resolve_pc SHALL be an input, 32 bits wide, carrying the PC of the resolving instruction.
REQ-009 The port flush SHALL be an input, 1 bit wide, and requests a pipeline flush that discards all entries.
REQ-010 The head outputs SHALL be head_valid (1 bit), head_pc_predict (32 bits), head_prediction (1 bit), head_status (2 bits), head_bias (2 bits) and head_total_weights (9 bits); these feed the BST, bias and perceptron update logic.
REQ-011 The port upd_fire SHALL be an output, 1 bit wide, giving a 1-cycle pulse when a resolve consumes a matching head.
REQ-012 The port sync_error SHALL be an output, 1 bit wide, giving a 1-cycle pulse when resolve_pc differs from the head PC.
REQ-013 The port underflow SHALL be an output, 1 bit wide, and is a sticky flag.
REQ-014 The port count SHALL be an output, $clog2(DEPTH)+1 bits wide, giving the current occupancy.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries, each 78 bits (pc, pc_predict, prediction, status, bias, total_weights), with a write pointer, a read pointer and a counter.
REQ-016 push_ready SHALL be the inverse of full, where full means count equals DEPTH; push_ready is independent of resolve_valid (no same-cycle pass-through when full).
REQ-017 A push SHALL be accepted when push_valid, push_ready and not flush are all high: the entry is written at the write pointer, the write pointer increments modulo DEPTH, and count increments.
REQ-018 A push attempted when full SHALL be dropped, with no state change.
REQ-019 Head outputs SHALL be combinational reads of the entry at the read pointer, with head_valid equal to (count != 0); while the queue is empty the head data outputs are don't-care.
REQ-020 A resolve with the queue non-empty and resolve_pc equal to the head pc SHALL pop the head: the read pointer increments and count decrements; upd_fire pulses on the following cycle (registered).
REQ-021 A resolve with the queue non-empty and resolve_pc not equal to the head pc SHALL register a sync_error pulse on the next cycle and clear all entries, as for a flush.
REQ-022 A resolve with the queue empty SHALL set underflow; underflow stays high until rst; pointers are unchanged and no upd_fire is generated.
REQ-023 A push and a matching pop in the same cycle with count between 1 and DEPTH-1 SHALL both occur, leaving count unchanged.
REQ-024 A push and a resolve in the same cycle on an empty queue SHALL accept the push and treat the resolve as underflow.
REQ-025 flush SHALL zero both pointers and count at the next edge; a matching resolve in the same cycle still produces upd_fire, while any push in that cycle is discarded.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0; count never exceeds DEPTH and never goes below 0.
REQ-027 Entry storage SHALL not require reset; only pointers, count and flags are reset.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set count=0, both pointers=0, head_valid=0, push_ready=1, upd_fire=0, sync_error=0 and underflow=0.
REQ-029 rst SHALL override push, resolve and flush in the same cycle.
REQ-030 Assertion of rst mid-operation SHALL discard all in-flight entries.

Verification
REQ-031 Fill and drain: push PCs 0x100, 0x104, 0x108, 0x10C -> push_ready=0 and count=4; a fifth push is dropped; four resolves in order -> upd_fire pulses 4 times, head_pc_predict follows the pushed order, and count ends at 0.
REQ-032 Wrap-around: run 10 push/resolve pairs interleaved with DEPTH=4 -> all resolves match, sync_error never asserts, and the pointers wrap with no data corruption.
REQ-033 Mismatch: push 0x200 then 0x204; resolve_pc=0x204 -> sync_error pulses once, count=0, head_valid=0.
REQ-034 Flush with simultaneous events: count=3, flush+resolve(match)+push in one cycle -> upd_fire pulses, pushed entry lost, count=0.
REQ-035 Underflow: resolve on an empty queue -> underflow=1 and stays 1 across later pushes and pops; rst clears it to 0.
REQ-036 Reset mid-stream: count=2, rst with push_valid=1 -> count=0, push_ready=1, head_valid=0 on the next cycle.

Source files
------------

// File: rtl/bfn_pred_queue.sv
// bfn_pred_queue
//   In-flight branch prediction queue. Fetch pushes one entry per predicted
//   control-flow instruction. EX resolves the oldest entry by PC. The head
//   entry's prediction metadata feeds the BST, bias and perceptron update
//   logic.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   push_valid/ready      push handshake; ready is simply !full
//   push_*                push payload (pc, predicted pc, prediction,
//                         status, bias, total_weights)
//   resolve_valid/pc      resolve of the oldest in-flight instruction
//   flush                 discards every entry
//   head_*                combinational view of the oldest entry
//   upd_fire              registered pulse: a resolve matched and popped
//                         the head
//   sync_error            registered pulse: a resolve PC disagreed with
//                         the head
//   underflow             sticky: a resolve arrived while the queue was empty
//   count                 current occupancy
module bfn_pred_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_pc_predict,
  input  logic                     push_prediction,
  input  logic [1:0]               push_status,
  input  logic [1:0]               push_bias,
  input  logic [8:0]               push_total_weights,
  input  logic                     resolve_valid,
  input  logic [31:0]              resolve_pc,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [31:0]              head_pc_predict,
  output logic                     head_prediction,
  output logic [1:0]               head_status,
  output logic [1:0]               head_bias,
  output logic [8:0]               head_total_weights,
  output logic                     upd_fire,
  output logic                     sync_error,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_predict;
    logic        prediction;
    logic [1:0]  status;
    logic [1:0]  bias;
    logic [8:0]  total_weights;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            upd_fire_q, upd_fire_d;
  logic            sync_error_q, sync_error_d;
  logic            underflow_q, underflow_d;

  entry_t          head_e;
  entry_t          push_e;
  logic            full;
  logic            not_empty;
  logic            pop;
  logic            mismatch;
  logic            clear;
  logic            push_acc;

  assign head_e    = mem_q[rd_ptr_q];
  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);

  // A matching resolve pops even when flush is also high, so upd_fire still
  // reports it; the pop is then subsumed by the clear.
  assign pop      = resolve_valid && not_empty && (resolve_pc == head_e.pc);
  assign mismatch = resolve_valid && not_empty && (resolve_pc != head_e.pc);
  assign clear    = flush || mismatch;
  // A push in a clearing cycle would land in a queue that is being emptied,
  // so it is discarded along with everything else.
  assign push_acc = push_valid && !full && !clear;

  assign push_e = '{pc:            push_pc,
                    pc_predict:    push_pc_predict,
                    prediction:    push_prediction,
                    status:        push_status,
                    bias:          push_bias,
                    total_weights: push_total_weights};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    upd_fire_d   = pop;
    sync_error_d = mismatch;
    underflow_d  = underflow_q || (resolve_valid && !not_empty);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: natural PW-bit overflow is the modulo wrap.
      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      upd_fire_q   <= 1'b0;
      sync_error_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      upd_fire_q   <= upd_fire_d;
      sync_error_q <= sync_error_d;
      underflow_q  <= underflow_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_q[wr_ptr_q] <= push_e;
  end

  assign push_ready         = !full;
  assign head_valid         = not_empty;
  assign head_pc_predict    = head_e.pc_predict;
  assign head_prediction    = head_e.prediction;
  assign head_status        = head_e.status;
  assign head_bias          = head_e.bias;
  assign head_total_weights = head_e.total_weights;
  assign upd_fire           = upd_fire_q;
  assign sync_error         = sync_error_q;
  assign underflow          = underflow_q;
  assign count              = count_q;

endmodule

// File: tb/tb_bfn_pred_queue.sv
module tb_bfn_pred_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_pc_predict;
  logic        push_prediction;
  logic [1:0]  push_status;
  logic [1:0]  push_bias;
  logic [8:0]  push_total_weights;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        flush;
  logic        head_valid;
  logic [31:0] head_pc_predict;
  logic        head_prediction;
  logic [1:0]  head_status;
  logic [1:0]  head_bias;
  logic [8:0]  head_total_weights;
  logic        upd_fire;
  logic        sync_error;
  logic        underflow;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  bfn_pred_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_pc(push_pc), .push_pc_predict(push_pc_predict),
    .push_prediction(push_prediction), .push_status(push_status),
    .push_bias(push_bias), .push_total_weights(push_total_weights),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .flush(flush),
    .head_valid(head_valid), .head_pc_predict(head_pc_predict),
    .head_prediction(head_prediction), .head_status(head_status),
    .head_bias(head_bias), .head_total_weights(head_total_weights),
    .upd_fire(upd_fire), .sync_error(sync_error), .underflow(underflow),
    .count(count)
  );

  // Reference model: an ordered list of in-flight entries plus the flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp;
    logic        pred;
    logic [1:0]  st;
    logic [1:0]  bias;
    logic [8:0]  tw;
  } ent_t;

  ent_t mq[$];
  logic m_upd, m_serr, m_und;
  int   checks = 0;
  int   errors = 0;
  int   fires  = 0;
  int   serrs  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; push_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    push_pc = '0; push_pc_predict = '0; push_prediction = 1'b0;
    push_status = '0; push_bias = '0; push_total_weights = '0; resolve_pc = '0;
  endtask

  task automatic set_push(input logic [31:0] pc);
    push_valid         = 1'b1;
    push_pc            = pc;
    push_pc_predict    = pc + 32'h40 + {$urandom_range(0, 255), 2'b00};
    push_prediction    = 1'($urandom);
    push_status        = 2'($urandom);
    push_bias          = 2'($urandom);
    push_total_weights = 9'($urandom);
  endtask

  task automatic set_resolve(input logic [31:0] pc);
    resolve_valid = 1'b1;
    resolve_pc    = pc;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".head_valid"}, 32'(head_valid), 32'(n != 0));
    chk({tag, ".push_ready"}, 32'(push_ready), 32'(n != DEPTH));
    chk({tag, ".upd_fire"}, 32'(upd_fire), 32'(m_upd));
    chk({tag, ".sync_error"}, 32'(sync_error), 32'(m_serr));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_und));
    if (n != 0) begin
      chk({tag, ".head_pc_predict"}, head_pc_predict, mq[0].pcp);
      chk({tag, ".head_meta"},
          32'({head_prediction, head_status, head_bias, head_total_weights}),
          32'({mq[0].pred, mq[0].st, mq[0].bias, mq[0].tw}));
    end
  endtask

  // Check the current outputs, advance the model by one clock using the
  // driven inputs, clock the DUT, then return inputs to idle.
  task automatic cycle(input string tag);
    ent_t e;
    logic was_empty, was_full, hit, miss;
    check_outputs(tag);
    if (rst) begin
      mq.delete();
      m_upd = 1'b0; m_serr = 1'b0; m_und = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      hit  = resolve_valid && !was_empty && (resolve_pc == mq[0].pc);
      miss = resolve_valid && !was_empty && (resolve_pc != mq[0].pc);
      if (resolve_valid && was_empty) m_und = 1'b1;
      m_upd  = hit;
      m_serr = miss;
      if (flush || miss) begin
        mq.delete();
      end else begin
        if (hit) void'(mq.pop_front());
        if (push_valid && !was_full) begin
          e.pc = push_pc; e.pcp = push_pc_predict; e.pred = push_prediction;
          e.st = push_status; e.bias = push_bias; e.tw = push_total_weights;
          mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (upd_fire) fires++;
    if (sync_error) serrs++;
    idle();
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10C;

    // Reset
    idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    mq.delete(); m_upd = 1'b0; m_serr = 1'b0; m_und = 1'b0;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.push_ready", 32'(push_ready), 32'd1);
    chk("reset.head_valid", 32'(head_valid), 32'd0);
    chk("reset.flags", 32'({upd_fire, sync_error, underflow}), 32'd0);
    idle();

    // Fill and drain
    for (int i = 0; i < 4; i++) begin set_push(pcs[i]); cycle("fill"); end
    chk("fill.count4", 32'(count), 32'd4);
    chk("fill.not_ready", 32'(push_ready), 32'd0);
    set_push(32'h110); cycle("fill.drop");
    chk("fill.drop_count", 32'(count), 32'd4);
    fires = 0;
    for (int i = 0; i < 4; i++) begin set_resolve(pcs[i]); cycle("drain"); end
    cycle("drain.tail");
    chk("drain.fires", 32'(fires), 32'd4);
    chk("drain.count0", 32'(count), 32'd0);

    // Wrap-around: 10 push/resolve pairs, overlapping push with resolve
    fires = 0; serrs = 0;
    set_push(32'h1000); cycle("wrap.first");
    for (int i = 1; i < 10; i++) begin
      set_push(32'h1000 + 32'(i * 4));
      set_resolve(32'h1000 + 32'((i - 1) * 4));
      cycle("wrap.pair");
    end
    set_resolve(32'h1000 + 32'(9 * 4)); cycle("wrap.last");
    cycle("wrap.tail");
    chk("wrap.fires", 32'(fires), 32'd10);
    chk("wrap.no_sync_error", 32'(serrs), 32'd0);

    // Mismatch
    set_push(32'h200); cycle("mis.push0");
    set_push(32'h204); cycle("mis.push1");
    serrs = 0;
    set_resolve(32'h204); cycle("mis.resolve");
    chk("mis.sync_error", 32'(sync_error), 32'd1);
    chk("mis.count", 32'(count), 32'd0);
    chk("mis.head_valid", 32'(head_valid), 32'd0);
    cycle("mis.after");
    chk("mis.one_pulse", 32'(serrs), 32'd1);

    // Flush with simultaneous match-resolve and push at count=3
    for (int i = 0; i < 3; i++) begin set_push(32'h300 + 32'(i * 4)); cycle("fl.fill"); end
    chk("fl.count3", 32'(count), 32'd3);
    flush = 1'b1; set_resolve(32'h300); set_push(32'h30C); cycle("fl.event");
    chk("fl.upd_fire", 32'(upd_fire), 32'd1);
    chk("fl.count0", 32'(count), 32'd0);
    cycle("fl.after");

    // Underflow is sticky across later traffic until reset
    set_resolve(32'h400); set_push(32'h400); cycle("und.event");
    chk("und.set", 32'(underflow), 32'd1);
    set_resolve(32'h400); cycle("und.pop");
    set_push(32'h404); cycle("und.push");
    chk("und.sticky", 32'(underflow), 32'd1);

    // Reset mid-stream with count=2 and push_valid high
    set_push(32'h408); cycle("rst.fill");
    chk("rst.count2", 32'(count), 32'd2);
    rst = 1'b1; set_push(32'h40C); cycle("rst.event");
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.push_ready", 32'(push_ready), 32'd1);
    chk("rst.head_valid", 32'(head_valid), 32'd0);
    chk("rst.underflow_clr", 32'(underflow), 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic bad_resolve;
      bad_resolve = 1'b0;
      if ($urandom_range(0, 63) == 0) rst = 1'b1;
      if ($urandom_range(0, 15) == 0) flush = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        if (mq.size() != 0 && $urandom_range(0, 7) != 0) begin
          set_resolve(mq[0].pc);
        end else begin
          set_resolve(32'h8000 + {$urandom_range(0, 1023), 2'b00});
          bad_resolve = (mq.size() != 0) && (resolve_pc != mq[0].pc);
        end
      end
      // Pushing into a cycle whose resolve mismatches is avoided.
      if (!bad_resolve && $urandom_range(0, 1) == 1)
        set_push(32'h2000 + 32'(n * 4));
      cycle("rand");
    end
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
